exit_gate_controller: RTL and testbench

EXIT_GATE_CONTROLLER -- requirements
Module: exit_gate_controller

---
 rtl/parking_pkg.sv | 17 +
 rtl/occupancy_counter.sv | 22 ++
 rtl/exit_gate_controller.sv | 139 +++++++++++++
 tb/tb_exit_gate_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared sizes and the exit FSM state type for the parking exit gate block.
package parking_pkg;

  localparam int SPOTS  = 8;
  localparam int SPOT_W = 3;
  localparam int TIME_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    BILL  = 3'd2,
    GATE  = 3'd3,
    ERR   = 3'd4
  } exit_state_t;

endpackage

// File: rtl/occupancy_counter.sv
// Number of occupied and free spots derived straight from the occupancy map.
module occupancy_counter
  import parking_pkg::*;
(
  input  logic [SPOTS-1:0] occupancy,
  output logic [3:0]       parked,
  output logic [3:0]       empty
);

  logic [3:0] count;

  // Population count of the occupancy bits; free spots are the remainder.
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < SPOTS; i++) begin
      count = count + {3'b000, occupancy[i]};
    end
    parked = count;
    empty  = 4'(SPOTS) - count;
  end

endmodule

// File: rtl/exit_gate_controller.sv
// Parking exit gate controller: tracks per-spot entry times, validates exit
// tokens, bills the parked duration and drives the exit barrier.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for exit_req; token and time stamp latched on request
//   CHECK | decoded spot looked up in the occupancy map
//   BILL  | duration computed, spot freed, exit_ack pulsed on leaving
//   GATE  | barrier held open; down-counter runs to terminal count zero
//   ERR   | token pointed at a free spot; exit_err pulsed on leaving
module exit_gate_controller
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_valid,
  input  logic [SPOT_W-1:0] entry_spot,
  input  logic              exit_req,
  input  logic [SPOT_W-1:0] exit_token,
  input  logic [SPOT_W-1:0] pattern,
  input  logic [TIME_W-1:0] time_now,
  output logic              busy,
  output logic              exit_ack,
  output logic              exit_err,
  output logic              entry_err,
  output logic              gate_open,
  output logic [TIME_W-1:0] time_total,
  output logic [SPOTS-1:0]  occupancy,
  output logic [3:0]        parked,
  output logic [3:0]        empty
);

  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);

  exit_state_t       state_q, state_d;
  logic [SPOT_W-1:0] spot_q;
  logic [TIME_W-1:0] tout_q;
  logic [CNT_W-1:0]  gate_cnt_q;
  logic [SPOTS-1:0]  occ_q, occ_d;
  logic [TIME_W-1:0] time_in_q [SPOTS];
  logic              entry_ok;
  logic              entry_clash;
  logic              exit_accept;

  // Entries are judged against the registered map, so a clash with the spot
  // being billed this edge still reports entry_err.
  assign entry_clash = entry_valid &  occ_q[entry_spot];
  assign entry_ok    = entry_valid & ~occ_q[entry_spot];
  assign exit_accept = (state_q == IDLE) & exit_req;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (exit_req) state_d = CHECK;
      CHECK:   state_d = occ_q[spot_q] ? BILL : ERR;
      BILL:    state_d = GATE;
      GATE:    if (gate_cnt_q == '0) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Exit request capture, billing, gate timer and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spot_q     <= '0;
      tout_q     <= '0;
      gate_cnt_q <= '0;
      time_total <= '0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;
      entry_err  <= 1'b0;
      gate_open  <= 1'b0;
    end else begin
      if (exit_accept) begin
        spot_q <= exit_token ^ pattern;
        tout_q <= time_now;
      end
      if (state_q == BILL) begin
        time_total <= tout_q - time_in_q[spot_q];
        gate_cnt_q <= GATE_LOAD;
      end else if ((state_q == GATE) && (gate_cnt_q != '0)) begin
        gate_cnt_q <= gate_cnt_q - 1'b1;
      end
      exit_ack  <= (state_q == BILL);
      exit_err  <= (state_q == ERR);
      entry_err <= entry_clash;
      gate_open <= (state_q == GATE) && (gate_cnt_q != '0);
    end
  end

  // Next occupancy: accepted entry sets its bit, billing clears the exit spot.
  always_comb begin
    occ_d = occ_q;
    if (entry_ok) occ_d[entry_spot] = 1'b1;
    if (state_q == BILL) occ_d[spot_q] = 1'b0;
  end

  // Occupancy map register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Entry time stamps, written only for accepted entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPOTS; i++) time_in_q[i] <= '0;
    end else if (entry_ok) begin
      time_in_q[entry_spot] <= time_now;
    end
  end

  assign busy      = (state_q != IDLE);
  assign occupancy = occ_q;

  occupancy_counter u_occupancy_counter (
    .occupancy (occ_q),
    .parked    (parked),
    .empty     (empty)
  );

endmodule

// File: tb/tb_exit_gate_controller.sv
// Bench for exit_gate_controller: transaction-level model plus directed cases.
module tb_exit_gate_controller;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       entry_valid = 1'b0;
  logic [2:0] entry_spot = '0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_token = '0;
  logic [2:0] pattern = '0;
  logic [7:0] time_now = '0;
  logic       busy, exit_ack, exit_err, entry_err, gate_open;
  logic [7:0] time_total, occupancy;
  logic [3:0] parked, empty;

  exit_gate_controller #(.GATE_CYCLES(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .entry_valid (entry_valid),
    .entry_spot  (entry_spot),
    .exit_req    (exit_req),
    .exit_token  (exit_token),
    .pattern     (pattern),
    .time_now    (time_now),
    .busy        (busy),
    .exit_ack    (exit_ack),
    .exit_err    (exit_err),
    .entry_err   (entry_err),
    .gate_open   (gate_open),
    .time_total  (time_total),
    .occupancy   (occupancy),
    .parked      (parked),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an exit is a record stamped with the edge number it was
  // accepted at; every observable event is a fixed offset from that stamp.
  int         cyc = 0;
  bit         active = 1'b0;
  int         s = 0;
  logic [2:0] sp = '0;
  logic [7:0] tout = '0;
  bit         ok = 1'b0;
  logic [7:0] m_occ = '0;
  logic [7:0] m_tin [8];
  logic [7:0] m_ttot = '0;
  bit m_ack = 0, m_err = 0, m_eerr = 0, m_gate = 0, m_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] occ_old;
    bit busy_pre;
    if (!rst_n) begin
      cyc = 0; active = 0; ok = 0;
      m_occ = '0; m_ttot = '0;
      for (int i = 0; i < 8; i++) m_tin[i] = '0;
      m_ack = 0; m_err = 0; m_eerr = 0; m_gate = 0; m_busy = 0;
    end else begin
      cyc++;
      occ_old  = m_occ;
      busy_pre = m_busy;
      m_ack = 0;
      m_err = 0;
      m_eerr = entry_valid && occ_old[entry_spot];
      if (entry_valid && !occ_old[entry_spot]) begin
        m_occ[entry_spot] = 1'b1;
        m_tin[entry_spot] = time_now;
      end
      if (active && cyc == s + 1) ok = occ_old[sp];
      if (active && cyc == s + 2) begin
        if (ok) begin
          m_ttot    = tout - m_tin[sp];
          m_occ[sp] = 1'b0;
          m_ack     = 1;
        end else begin
          m_err = 1;
        end
      end
      if (!busy_pre && exit_req) begin
        active = 1; s = cyc; sp = exit_token ^ pattern; tout = time_now; ok = 0;
      end
      if (active && cyc > s + 1 && cyc > (ok ? s + 2 + G : s + 1)) active = 0;
      m_busy = active;
      m_gate = active && ok && (cyc >= s + 3) && (cyc <= s + 2 + G);
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("exit_ack", int'(exit_ack), int'(m_ack));
      chk("exit_err", int'(exit_err), int'(m_err));
      chk("entry_err", int'(entry_err), int'(m_eerr));
      chk("gate_open", int'(gate_open), int'(m_gate));
      chk("time_total", int'(time_total), int'(m_ttot));
      chk("occupancy", int'(occupancy), int'(m_occ));
      chk("parked", int'(parked), $countones(m_occ));
      chk("empty", int'(empty), 8 - $countones(m_occ));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_entry(input logic [2:0] spot, input logic [7:0] t);
    entry_valid = 1'b1; entry_spot = spot; time_now = t;
    tick();
    entry_valid = 1'b0;
  endtask

  // Returns in the cycle right after the accepting edge (cycle n).
  task automatic do_exit(input logic [2:0] tok, input logic [2:0] pat, input logic [7:0] t);
    exit_req = 1'b1; exit_token = tok; pattern = pat; time_now = t;
    tick();
    exit_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_timeout", 1, 0);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;
    int acks;
    logic [7:0] occ_snap;

    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_parked", int'(parked), 0);
    chk("rst_empty", int'(empty), 8);
    chk("rst_gate", int'(gate_open), 0);

    // Basic bill: spot 5 in at 20, out at 50 via token 6 ^ pattern 3.
    do_entry(3'd5, 8'd20);
    tick();
    do_exit(3'd6, 3'd3, 8'd50);
    chk("ack_n", int'(exit_ack), 0);
    tick();
    chk("ack_n1", int'(exit_ack), 0);
    tick();
    chk("ack_n2", int'(exit_ack), 1);
    chk("total_30", int'(time_total), 30);
    chk("spot5_freed", int'(occupancy[5]), 0);
    chk("gate_n2", int'(gate_open), 0);
    cnt = 0;
    repeat (G + 2) begin tick(); cnt += int'(gate_open); end
    chk("gate_count", cnt, G);
    wait_idle();

    // Token decoding to free spot 2.
    occ_snap = occupancy;
    do_exit(3'd3, 3'd1, 8'd60);
    tick();
    tick();
    chk("err_n2", int'(exit_err), 1);
    chk("err_occ", int'(occupancy), int'(occ_snap));
    cnt = 0;
    repeat (G + 2) begin tick(); cnt += int'(gate_open) + int'(exit_err); end
    chk("err_no_gate", cnt, 0);

    // Time wrap: in at 250, out at 4.
    do_entry(3'd1, 8'd250);
    do_exit(3'd1, 3'd0, 8'd4);
    tick();
    tick();
    chk("total_wrap", int'(time_total), 10);
    wait_idle();

    // Double entry, busy exit_req ignored, entry to spot_q during BILL.
    do_entry(3'd6, 8'd70);
    do_entry(3'd3, 8'd71);
    chk("entry_first", int'(entry_err), 0);
    do_entry(3'd3, 8'd72);
    chk("entry_second", int'(entry_err), 1);
    do_exit(3'd3, 3'd0, 8'd80);
    exit_req = 1'b1; exit_token = 3'd6;
    tick();
    exit_req = 1'b0;
    entry_valid = 1'b1; entry_spot = 3'd3;
    tick();
    entry_valid = 1'b0;
    chk("bill_entry_err", int'(entry_err), 1);
    chk("bill_ack", int'(exit_ack), 1);
    chk("bill_spot_freed", int'(occupancy[3]), 0);
    chk("bill_total", int'(time_total), 9);
    acks = 0;
    repeat (G + 6) begin tick(); acks += int'(exit_ack) + int'(exit_err); end
    chk("busy_req_ignored", acks, 0);
    chk("spot6_kept", int'(occupancy[6]), 1);

    // Reset during the second gate cycle.
    do_entry(3'd4, 8'd90);
    do_exit(3'd4, 3'd0, 8'd95);
    tick();
    tick();
    tick();
    tick();
    chk("gate_c2", int'(gate_open), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gate_drop", int'(gate_open), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_ack", int'(exit_ack), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Randomized traffic checked by the model.
    for (int k = 0; k < 3000; k++) begin
      entry_valid = ($urandom_range(0, 99) < 30);
      entry_spot  = 3'($urandom_range(0, 7));
      exit_req    = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 19) == 0) pattern = 3'($urandom_range(0, 7));
      exit_token  = 3'($urandom_range(0, 7)) ^ pattern;
      time_now    = time_now + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) begin
        apply_reset();
      end else begin
        tick();
      end
    end
    entry_valid = 1'b0;
    exit_req = 1'b0;
    repeat (G + 6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
